// File: rtl/nvdla_dbb_initiator_pkg.sv
// Shared types for the DBB initiator: FSM state encoding and control/status bundles.
package nvdla_package;

    localparam int DBB_ADDR_W = 32;
    localparam int DBB_LEN_W  = 4;
    localparam int DBB_ID_W   = 8;

    typedef enum logic [2:0] {
        INIT_IDLE,
        INIT_WR_REQ,
        INIT_WR_DATA,
        INIT_WR_RSP,
        INIT_RD_REQ,
        INIT_RD_DATA,
        INIT_DONE
    } state_dbb_init_t;

    typedef struct packed {
        logic [DBB_ADDR_W-1:0] addr;
        logic [DBB_LEN_W-1:0]  len;
        logic [DBB_ID_W-1:0]   id;
    } dbb_req_t;

    typedef struct packed {
        logic                  start;
        logic                  rnw;
        logic [DBB_ADDR_W-1:0] addr;
        logic [DBB_LEN_W-1:0]  len;
        logic [DBB_ID_W-1:0]   id;
    } ctrl_dbb_init_t;

    typedef struct packed {
        logic busy;
        logic done;
        logic err;
    } flags_dbb_init_t;

endpackage

// File: rtl/nvdla_dbb_initiator.sv
// DBB master engine: turns one read or write job into request, data and response
// handshakes; data beats pass straight between the HWPE streams and the DBB ports.
module nvdla_dbb_initiator
    import nvdla_package::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    parameter int ID_W   = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                start_i,
    input  logic                rnw_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [LEN_W-1:0]    len_i,
    input  logic [ID_W-1:0]     id_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    input  logic [DATA_W-1:0]   data_i_data,
    input  logic [DATA_W/8-1:0] data_i_strb,
    input  logic                data_i_valid,
    output logic                data_i_ready,
    output logic [DATA_W-1:0]   data_o_data,
    output logic [DATA_W/8-1:0] data_o_strb,
    output logic                data_o_valid,
    input  logic                data_o_ready,
    output logic                wr_req_valid_o,
    input  logic                wr_req_ready_i,
    output logic [ADDR_W-1:0]   wr_req_addr_o,
    output logic [LEN_W-1:0]    wr_req_len_o,
    output logic [ID_W-1:0]     wr_req_id_o,
    output logic                wr_dat_valid_o,
    input  logic                wr_dat_ready_i,
    output logic [DATA_W-1:0]   wr_dat_data_o,
    output logic [DATA_W/8-1:0] wr_dat_strb_o,
    output logic                wr_dat_last_o,
    input  logic                wr_rsp_valid_i,
    output logic                wr_rsp_ready_o,
    input  logic [ID_W-1:0]     wr_rsp_id_i,
    output logic                rd_req_valid_o,
    input  logic                rd_req_ready_i,
    output logic [ADDR_W-1:0]   rd_req_addr_o,
    output logic [LEN_W-1:0]    rd_req_len_o,
    output logic [ID_W-1:0]     rd_req_id_o,
    input  logic                rd_dat_valid_i,
    output logic                rd_dat_ready_o,
    input  logic [DATA_W-1:0]   rd_dat_data_i,
    input  logic [ID_W-1:0]     rd_dat_id_i,
    input  logic                rd_dat_last_i
);

    state_dbb_init_t  state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              rnw_q, rnw_d;
    logic              err_q, err_d;

    logic            in_wr_data, in_rd_data;
    logic            wr_dat_hs, rd_dat_hs, last_beat;
    flags_dbb_init_t flags;

    // Direction qualifier keeps each data path dead unless the latched job matches it.
    assign in_wr_data = (state_q == INIT_WR_DATA) && !rnw_q;
    assign in_rd_data = (state_q == INIT_RD_DATA) && rnw_q;
    assign last_beat  = (cnt_q == len_q);
    assign wr_dat_hs  = in_wr_data && data_i_valid && wr_dat_ready_i;
    assign rd_dat_hs  = in_rd_data && rd_dat_valid_i && data_o_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        addr_d  = addr_q;
        id_d    = id_q;
        rnw_d   = rnw_q;
        err_d   = err_q;
        case (state_q)
            INIT_IDLE: begin
                if (start_i) begin
                    addr_d  = addr_i;
                    len_d   = len_i;
                    id_d    = id_i;
                    rnw_d   = rnw_i;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = rnw_i ? INIT_RD_REQ : INIT_WR_REQ;
                end
            end
            INIT_WR_REQ: begin
                if (wr_req_ready_i) begin
                    cnt_d   = '0;
                    state_d = INIT_WR_DATA;
                end
            end
            INIT_WR_DATA: begin
                if (wr_dat_hs) begin
                    if (last_beat) state_d = INIT_WR_RSP;
                    else           cnt_d   = cnt_q + 1'b1;
                end
            end
            INIT_WR_RSP: begin
                if (wr_rsp_valid_i) begin
                    if (wr_rsp_id_i != id_q) err_d = 1'b1;
                    state_d = INIT_DONE;
                end
            end
            INIT_RD_REQ: begin
                if (rd_req_ready_i) begin
                    cnt_d   = '0;
                    state_d = INIT_RD_DATA;
                end
            end
            INIT_RD_DATA: begin
                if (rd_dat_hs) begin
                    if (rd_dat_id_i != id_q) err_d = 1'b1;
                    // Counter freezes at len: either the expected last beat or an early last ends the burst.
                    if (last_beat) begin
                        if (!rd_dat_last_i) err_d = 1'b1;
                        state_d = INIT_DONE;
                    end else if (rd_dat_last_i) begin
                        err_d   = 1'b1;
                        state_d = INIT_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            INIT_DONE: state_d = INIT_IDLE;
            default:   state_d = INIT_IDLE;
        endcase
        if (clear_i) begin
            state_d = INIT_IDLE;
            cnt_d   = '0;
            len_d   = '0;
            addr_d  = '0;
            id_d    = '0;
            rnw_d   = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= INIT_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            id_q    <= '0;
            rnw_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
            rnw_q   <= rnw_d;
            err_q   <= err_d;
        end
    end

    assign flags.busy = (state_q != INIT_IDLE);
    assign flags.done = (state_q == INIT_DONE);
    assign flags.err  = err_q;
    assign busy_o     = flags.busy;
    assign done_o     = flags.done;
    assign err_o      = flags.err;

    assign wr_req_valid_o = (state_q == INIT_WR_REQ) && !rnw_q;
    assign wr_req_addr_o  = addr_q;
    assign wr_req_len_o   = len_q;
    assign wr_req_id_o    = id_q;
    assign rd_req_valid_o = (state_q == INIT_RD_REQ) && rnw_q;
    assign rd_req_addr_o  = addr_q;
    assign rd_req_len_o   = len_q;
    assign rd_req_id_o    = id_q;

    assign wr_dat_valid_o = in_wr_data && data_i_valid;
    assign data_i_ready   = in_wr_data && wr_dat_ready_i;
    assign wr_dat_data_o  = data_i_data;
    assign wr_dat_strb_o  = data_i_strb;
    assign wr_dat_last_o  = in_wr_data && last_beat;
    assign wr_rsp_ready_o = (state_q == INIT_WR_RSP);

    assign data_o_valid   = in_rd_data && rd_dat_valid_i;
    assign rd_dat_ready_o = in_rd_data && data_o_ready;
    assign data_o_data    = rd_dat_data_i;
    assign data_o_strb    = '1;

endmodule

// File: tb/tb_nvdla_dbb_initiator.sv
// Directed bench for the DBB initiator: each task drives one scenario and checks inline.
module tb_nvdla_dbb_initiator;

    logic        clk_i = 1'b0;
    logic        rst_i, clear_i, start_i, rnw_i;
    logic [31:0] addr_i;
    logic [3:0]  len_i;
    logic [7:0]  id_i;
    logic        busy_o, done_o, err_o;
    logic [31:0] data_i_data;
    logic [3:0]  data_i_strb;
    logic        data_i_valid, data_i_ready;
    logic [31:0] data_o_data;
    logic [3:0]  data_o_strb;
    logic        data_o_valid, data_o_ready;
    logic        wr_req_valid_o, wr_req_ready_i;
    logic [31:0] wr_req_addr_o;
    logic [3:0]  wr_req_len_o;
    logic [7:0]  wr_req_id_o;
    logic        wr_dat_valid_o, wr_dat_ready_i;
    logic [31:0] wr_dat_data_o;
    logic [3:0]  wr_dat_strb_o;
    logic        wr_dat_last_o;
    logic        wr_rsp_valid_i, wr_rsp_ready_o;
    logic [7:0]  wr_rsp_id_i;
    logic        rd_req_valid_o, rd_req_ready_i;
    logic [31:0] rd_req_addr_o;
    logic [3:0]  rd_req_len_o;
    logic [7:0]  rd_req_id_o;
    logic        rd_dat_valid_i, rd_dat_ready_o;
    logic [31:0] rd_dat_data_i;
    logic [7:0]  rd_dat_id_i;
    logic        rd_dat_last_i;

    int tests  = 0;
    int failed = 0;

    always #5 clk_i = ~clk_i;

    nvdla_dbb_initiator #(.ADDR_W(32), .DATA_W(32), .LEN_W(4), .ID_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i), .rnw_i(rnw_i),
        .addr_i(addr_i), .len_i(len_i), .id_i(id_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .data_i_data(data_i_data), .data_i_strb(data_i_strb), .data_i_valid(data_i_valid),
        .data_i_ready(data_i_ready),
        .data_o_data(data_o_data), .data_o_strb(data_o_strb), .data_o_valid(data_o_valid),
        .data_o_ready(data_o_ready),
        .wr_req_valid_o(wr_req_valid_o), .wr_req_ready_i(wr_req_ready_i),
        .wr_req_addr_o(wr_req_addr_o), .wr_req_len_o(wr_req_len_o), .wr_req_id_o(wr_req_id_o),
        .wr_dat_valid_o(wr_dat_valid_o), .wr_dat_ready_i(wr_dat_ready_i),
        .wr_dat_data_o(wr_dat_data_o), .wr_dat_strb_o(wr_dat_strb_o), .wr_dat_last_o(wr_dat_last_o),
        .wr_rsp_valid_i(wr_rsp_valid_i), .wr_rsp_ready_o(wr_rsp_ready_o), .wr_rsp_id_i(wr_rsp_id_i),
        .rd_req_valid_o(rd_req_valid_o), .rd_req_ready_i(rd_req_ready_i),
        .rd_req_addr_o(rd_req_addr_o), .rd_req_len_o(rd_req_len_o), .rd_req_id_o(rd_req_id_o),
        .rd_dat_valid_i(rd_dat_valid_i), .rd_dat_ready_o(rd_dat_ready_o),
        .rd_dat_data_i(rd_dat_data_i), .rd_dat_id_i(rd_dat_id_i), .rd_dat_last_i(rd_dat_last_i)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        clear_i = 0; start_i = 0; rnw_i = 0; addr_i = 0; len_i = 0; id_i = 0;
        data_i_data = 0; data_i_strb = 0; data_i_valid = 0; data_o_ready = 0;
        wr_req_ready_i = 0; wr_dat_ready_i = 0; wr_rsp_valid_i = 0; wr_rsp_id_i = 0;
        rd_req_ready_i = 0; rd_dat_valid_i = 0; rd_dat_data_i = 0; rd_dat_id_i = 0; rd_dat_last_i = 0;
    endtask

    task automatic start_job(input logic rnw, input logic [31:0] addr, input logic [3:0] len,
                             input logic [7:0] id);
        start_i = 1; rnw_i = rnw; addr_i = addr; len_i = len; id_i = id;
        step();
        start_i = 0;
    endtask

    task automatic req_handshake(input logic rnw);
        if (rnw) rd_req_ready_i = 1; else wr_req_ready_i = 1;
        step();
        rd_req_ready_i = 0; wr_req_ready_i = 0;
    endtask

    task automatic test_reset();
        rst_i = 1;
        idle_inputs();
        step(); step();
        tests++;
        if ({busy_o, done_o, err_o, wr_req_valid_o, rd_req_valid_o, wr_dat_valid_o,
             data_i_ready, data_o_valid, rd_dat_ready_o, wr_rsp_ready_o} !== 10'b0) begin
            failed++;
            $display("FAIL reset_outputs got busy=%b done=%b err=%b wrq=%b rdq=%b need all 0",
                     busy_o, done_o, err_o, wr_req_valid_o, rd_req_valid_o);
        end
        rst_i = 0;
        step();
    endtask

    task automatic test_write_basic();
        start_job(0, 32'h1000, 4'd3, 8'h5A);
        #1;
        tests++;
        if (wr_req_valid_o !== 1'b1 || wr_req_addr_o !== 32'h1000 || wr_req_len_o !== 4'd3 ||
            wr_req_id_o !== 8'h5A || busy_o !== 1'b1 || rd_req_valid_o !== 1'b0) begin
            failed++;
            $display("FAIL wr_req got v=%b a=%h l=%0d id=%h busy=%b need 1/1000/3/5a/1",
                     wr_req_valid_o, wr_req_addr_o, wr_req_len_o, wr_req_id_o, busy_o);
        end
        step();
        tests++;
        if (wr_req_valid_o !== 1'b1 || wr_req_addr_o !== 32'h1000 || wr_dat_valid_o !== 1'b0) begin
            failed++;
            $display("FAIL wr_req_hold got v=%b a=%h need 1/1000", wr_req_valid_o, wr_req_addr_o);
        end
        req_handshake(0);
        wr_dat_ready_i = 1;
        for (int b = 0; b < 4; b++) begin
            data_i_valid = 1; data_i_data = 32'hA0 + b; data_i_strb = 4'hF;
            #1;
            tests++;
            if (wr_dat_valid_o !== 1'b1 || wr_dat_data_o !== 32'hA0 + b || wr_dat_strb_o !== 4'hF ||
                wr_dat_last_o !== (b == 3) || data_i_ready !== 1'b1) begin
                failed++;
                $display("FAIL wr_beat%0d got v=%b d=%h last=%b rdy=%b need 1/%h/%b/1", b,
                         wr_dat_valid_o, wr_dat_data_o, wr_dat_last_o, data_i_ready, 32'hA0 + b, b == 3);
            end
            step();
        end
        data_i_valid = 0; wr_dat_ready_i = 0;
        #1;
        tests++;
        if (wr_rsp_ready_o !== 1'b1 || done_o !== 1'b0 || wr_dat_valid_o !== 1'b0) begin
            failed++;
            $display("FAIL wr_rsp_wait got rsp_rdy=%b done=%b need 1/0", wr_rsp_ready_o, done_o);
        end
        wr_rsp_valid_i = 1; wr_rsp_id_i = 8'h5A;
        step();
        wr_rsp_valid_i = 0;
        tests++;
        if (done_o !== 1'b1 || err_o !== 1'b0 || busy_o !== 1'b1) begin
            failed++;
            $display("FAIL wr_done got done=%b err=%b busy=%b need 1/0/1", done_o, err_o, busy_o);
        end
        step();
        tests++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            failed++;
            $display("FAIL wr_done_pulse got done=%b busy=%b need 0/0", done_o, busy_o);
        end
    endtask

    task automatic test_read_single();
        start_job(1, 32'h2000, 4'd0, 8'h11);
        #1;
        tests++;
        if (rd_req_valid_o !== 1'b1 || rd_req_addr_o !== 32'h2000 || rd_req_len_o !== 4'd0 ||
            rd_req_id_o !== 8'h11 || wr_req_valid_o !== 1'b0) begin
            failed++;
            $display("FAIL rd_req got v=%b a=%h l=%0d id=%h need 1/2000/0/11",
                     rd_req_valid_o, rd_req_addr_o, rd_req_len_o, rd_req_id_o);
        end
        req_handshake(1);
        data_o_ready = 1;
        rd_dat_valid_i = 1; rd_dat_data_i = 32'hDEAD; rd_dat_last_i = 1; rd_dat_id_i = 8'h11;
        #1;
        tests++;
        if (data_o_valid !== 1'b1 || data_o_data !== 32'hDEAD || data_o_strb !== 4'hF ||
            rd_dat_ready_o !== 1'b1 || done_o !== 1'b0) begin
            failed++;
            $display("FAIL rd_beat got v=%b d=%h s=%h rdy=%b need 1/dead/f/1",
                     data_o_valid, data_o_data, data_o_strb, rd_dat_ready_o);
        end
        step();
        rd_dat_valid_i = 0; rd_dat_last_i = 0; data_o_ready = 0;
        tests++;
        if (done_o !== 1'b1 || err_o !== 1'b0 || rd_dat_ready_o !== 1'b0) begin
            failed++;
            $display("FAIL rd_done got done=%b err=%b need 1/0", done_o, err_o);
        end
        step();
    endtask

    task automatic test_backpressure();
        int idx;
        start_job(0, 32'h3000, 4'd15, 8'h33);
        req_handshake(0);
        idx = 0;
        for (int c = 0; c < 400 && idx < 16; c++) begin
            data_i_valid = 1; data_i_data = 32'hB00 + idx; data_i_strb = 4'h5;
            wr_dat_ready_i = 1'($urandom_range(0, 1));
            #1;
            tests++;
            if (wr_dat_valid_o !== 1'b1 || wr_dat_data_o !== 32'hB00 + idx || wr_dat_strb_o !== 4'h5 ||
                wr_dat_last_o !== (idx == 15) || data_i_ready !== wr_dat_ready_i || wr_rsp_ready_o !== 1'b0) begin
                failed++;
                $display("FAIL bp_wr_beat%0d got v=%b d=%h last=%b rdy=%b rsp=%b need 1/%h/%b/%b/0", idx,
                         wr_dat_valid_o, wr_dat_data_o, wr_dat_last_o, data_i_ready, wr_rsp_ready_o,
                         32'hB00 + idx, idx == 15, wr_dat_ready_i);
            end
            if (wr_dat_ready_i) idx++;
            step();
        end
        data_i_valid = 0; wr_dat_ready_i = 0;
        #1;
        tests++;
        if (idx !== 16 || wr_rsp_ready_o !== 1'b1) begin
            failed++;
            $display("FAIL bp_wr_count got beats=%0d rsp_rdy=%b need 16/1", idx, wr_rsp_ready_o);
        end
        wr_rsp_valid_i = 1; wr_rsp_id_i = 8'h33;
        step();
        wr_rsp_valid_i = 0;
        tests++;
        if (done_o !== 1'b1 || err_o !== 1'b0) begin
            failed++;
            $display("FAIL bp_wr_done got done=%b err=%b need 1/0", done_o, err_o);
        end
        step();
        start_job(1, 32'h3800, 4'd15, 8'h44);
        req_handshake(1);
        idx = 0;
        for (int c = 0; c < 400 && idx < 16; c++) begin
            rd_dat_valid_i = 1; rd_dat_data_i = 32'hC00 + idx; rd_dat_id_i = 8'h44;
            rd_dat_last_i = (idx == 15);
            data_o_ready = 1'($urandom_range(0, 1));
            #1;
            tests++;
            if (data_o_valid !== 1'b1 || data_o_data !== 32'hC00 + idx || rd_dat_ready_o !== data_o_ready ||
                done_o !== 1'b0) begin
                failed++;
                $display("FAIL bp_rd_beat%0d got v=%b d=%h rdy=%b done=%b need 1/%h/%b/0", idx,
                         data_o_valid, data_o_data, rd_dat_ready_o, done_o, 32'hC00 + idx, data_o_ready);
            end
            if (data_o_ready) idx++;
            step();
        end
        rd_dat_valid_i = 0; rd_dat_last_i = 0; data_o_ready = 0;
        tests++;
        if (idx !== 16 || done_o !== 1'b1 || err_o !== 1'b0) begin
            failed++;
            $display("FAIL bp_rd_done got beats=%0d done=%b err=%b need 16/1/0", idx, done_o, err_o);
        end
        step();
    endtask

    task automatic test_wr_id_error();
        start_job(0, 32'h4000, 4'd0, 8'h5A);
        req_handshake(0);
        data_i_valid = 1; data_i_data = 32'h77; data_i_strb = 4'hF; wr_dat_ready_i = 1;
        #1;
        tests++;
        if (wr_dat_last_o !== 1'b1) begin
            failed++;
            $display("FAIL err_len0_last got last=%b need 1", wr_dat_last_o);
        end
        step();
        data_i_valid = 0; wr_dat_ready_i = 0;
        wr_rsp_valid_i = 1; wr_rsp_id_i = 8'h22;
        step();
        wr_rsp_valid_i = 0;
        tests++;
        if (done_o !== 1'b1 || err_o !== 1'b1) begin
            failed++;
            $display("FAIL err_wr_rsp got done=%b err=%b need 1/1", done_o, err_o);
        end
        step();
        tests++;
        if (err_o !== 1'b1 || busy_o !== 1'b0) begin
            failed++;
            $display("FAIL err_sticky got err=%b busy=%b need 1/0", err_o, busy_o);
        end
        start_job(1, 32'h4100, 4'd0, 8'h44);
        tests++;
        if (err_o !== 1'b0 || rd_req_valid_o !== 1'b1) begin
            failed++;
            $display("FAIL err_clear_on_start got err=%b rdq=%b need 0/1", err_o, rd_req_valid_o);
        end
        req_handshake(1);
        data_o_ready = 1; rd_dat_valid_i = 1; rd_dat_id_i = 8'h45; rd_dat_last_i = 1;
        step();
        rd_dat_valid_i = 0; rd_dat_last_i = 0; data_o_ready = 0;
        tests++;
        if (done_o !== 1'b1 || err_o !== 1'b1) begin
            failed++;
            $display("FAIL err_rd_id got done=%b err=%b need 1/1", done_o, err_o);
        end
        step();
    endtask

    task automatic test_rd_early_last();
        start_job(1, 32'h5000, 4'd3, 8'h77);
        req_handshake(1);
        data_o_ready = 1; rd_dat_valid_i = 1; rd_dat_id_i = 8'h77; rd_dat_data_i = 32'h1; rd_dat_last_i = 0;
        step();
        tests++;
        if (done_o !== 1'b0 || err_o !== 1'b0 || rd_dat_ready_o !== 1'b1) begin
            failed++;
            $display("FAIL early_beat0 got done=%b err=%b rdy=%b need 0/0/1", done_o, err_o, rd_dat_ready_o);
        end
        rd_dat_data_i = 32'h2; rd_dat_last_i = 1;
        step();
        rd_dat_valid_i = 0; rd_dat_last_i = 0; data_o_ready = 0;
        tests++;
        if (done_o !== 1'b1 || err_o !== 1'b1 || rd_dat_ready_o !== 1'b0) begin
            failed++;
            $display("FAIL early_last got done=%b err=%b rdy=%b need 1/1/0", done_o, err_o, rd_dat_ready_o);
        end
        step();
    endtask

    task automatic test_reset_midburst();
        start_job(0, 32'h6000, 4'd3, 8'h5A);
        req_handshake(0);
        wr_dat_ready_i = 1; data_i_valid = 1; data_i_strb = 4'hF;
        for (int b = 0; b < 2; b++) begin
            data_i_data = 32'hE0 + b;
            step();
        end
        data_i_data = 32'hE2;
        #1;
        rst_i = 1;
        #1;
        tests++;
        if ({busy_o, done_o, err_o, wr_dat_valid_o, data_i_ready, wr_req_valid_o, wr_rsp_ready_o,
             wr_dat_last_o} !== 8'b0) begin
            failed++;
            $display("FAIL rst_midburst got busy=%b wdv=%b rdy=%b need all 0", busy_o, wr_dat_valid_o, data_i_ready);
        end
        step();
        rst_i = 0; data_i_valid = 0; wr_dat_ready_i = 0;
        step();
        start_job(0, 32'h6100, 4'd1, 8'h66);
        req_handshake(0);
        wr_dat_ready_i = 1; data_i_valid = 1;
        step(); step();
        data_i_valid = 0; wr_dat_ready_i = 0;
        wr_rsp_valid_i = 1; wr_rsp_id_i = 8'h66;
        #1;
        tests++;
        if (wr_rsp_ready_o !== 1'b1) begin
            failed++;
            $display("FAIL post_rst_rsp got rsp_rdy=%b need 1", wr_rsp_ready_o);
        end
        step();
        wr_rsp_valid_i = 0;
        tests++;
        if (done_o !== 1'b1 || err_o !== 1'b0) begin
            failed++;
            $display("FAIL post_rst_done got done=%b err=%b need 1/0", done_o, err_o);
        end
        step();
    endtask

    task automatic test_clear_and_ignore_start();
        start_job(1, 32'h7000, 4'd3, 8'h12);
        start_i = 1; rnw_i = 0; addr_i = 32'h9999; id_i = 8'h99;
        step();
        start_i = 0;
        tests++;
        if (rd_req_valid_o !== 1'b1 || rd_req_addr_o !== 32'h7000 || rd_req_id_o !== 8'h12 ||
            wr_req_valid_o !== 1'b0) begin
            failed++;
            $display("FAIL start_ignored got rdq=%b a=%h id=%h wrq=%b need 1/7000/12/0",
                     rd_req_valid_o, rd_req_addr_o, rd_req_id_o, wr_req_valid_o);
        end
        req_handshake(1);
        data_o_ready = 1; rd_dat_valid_i = 1; rd_dat_id_i = 8'h12;
        step();
        clear_i = 1;
        step();
        clear_i = 0; rd_dat_valid_i = 0; data_o_ready = 0;
        tests++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || rd_dat_ready_o !== 1'b0 || err_o !== 1'b0) begin
            failed++;
            $display("FAIL clear_abort got busy=%b done=%b rdy=%b err=%b need 0/0/0/0",
                     busy_o, done_o, rd_dat_ready_o, err_o);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_basic();
        test_read_single();
        test_backpressure();
        test_wr_id_error();
        test_rd_early_last();
        test_reset_midburst();
        test_clear_and_ignore_start();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/nvdla_dbb_initiator.md
Name: nvdla_dbb_initiator

Overview:
- Master-side DBB engine. Turns one HWPE-controlled job (read or write burst) into DBB request, data and response handshakes towards an NVDLA-style DBB responder.
- Write data comes from an HWPE sink stream; read data goes out on an HWPE source stream.
- Used as the traffic generator that drives a DBB slave port, both in the cluster and in the DBB loopback testbench.

Parameters:
- ADDR_W, 32, DBB address width (byte address)
- DATA_W, 32, DBB and stream data width
- LEN_W, 4, burst length field; encodes beats-1
- ID_W, 8, transaction ID width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- clear_i  in  1  synchronous soft clear, same effect as reset
- start_i  in  1  job start pulse; sampled only in IDLE
- rnw_i  in  1  1 = read job, 0 = write job
- addr_i  in  ADDR_W  burst base address
- len_i  in  LEN_W  beats-1
- id_i  in  ID_W  transaction ID
- busy_o  out  1  high whenever state is not IDLE
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky ID-mismatch flag; cleared by the next accepted start
- data_i  sink stream  DATA_W  write data (data, strb, valid, ready)
- data_o  source stream  DATA_W  read data (data, strb all-ones, valid, ready)
- wr_req_valid_o/ready_i, wr_req_addr_o, wr_req_len_o, wr_req_id_o  DBB write request
- wr_dat_valid_o/ready_i, wr_dat_data_o, wr_dat_strb_o (DATA_W/8), wr_dat_last_o  DBB write data
- wr_rsp_valid_i/ready_o, wr_rsp_id_i  DBB write response
- rd_req_valid_o/ready_i, rd_req_addr_o, rd_req_len_o, rd_req_id_o  DBB read request
- rd_dat_valid_i/ready_o, rd_dat_data_i, rd_dat_id_i, rd_dat_last_i  DBB read data

Behaviour:
- Reset/clear: state IDLE, beat counter 0, latched addr/len/id/rnw 0, err_o 0. All valid/ready outputs and done_o are 0.
- IDLE: start_i=1 latches addr/len/id/rnw and clears err_o. Next state is RD_REQ if rnw=1, else WR_REQ. start_i is ignored in every other state.
- WR_REQ: wr_req_valid_o=1 with the latched fields, held stable until wr_req_ready_i. On the handshake go to WR_DATA with cnt=0.
- WR_DATA: combinational pass-through.
  - wr_dat_valid_o = data_i.valid.
  - data_i.ready = wr_dat_ready_i.
  - data and strb are copied straight through.
  - wr_dat_last_o = (cnt == len).
  - Each handshake increments cnt. The handshake with last=1 goes to WR_RSP.
- WR_RSP: wr_rsp_ready_o=1. On wr_rsp_valid_i:
  - if wr_rsp_id_i != latched id, set err_o;
  - go to DONE.
- RD_REQ: mirrors WR_REQ on the rd_req_* port. On the handshake go to RD_DATA with cnt=0.
- RD_DATA: combinational pass-through.
  - data_o.valid = rd_dat_valid_i.
  - rd_dat_ready_o = data_o.ready.
  - Each handshake increments cnt.
  - Any beat with rd_dat_id_i != id sets err_o.
  - The beat where cnt == len goes to DONE. That beat also sets err_o if rd_dat_last_i=0.
  - rd_dat_last_i=1 arriving early also sets err_o and goes to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE. busy_o stays high during DONE.
- Latency: start to request valid is 1 cycle. The data path adds 0 cycles (no buffering). Final handshake to done_o is 1 cycle.
- Counter is LEN_W bits and never wraps: it stops at len. len=0 is a single-beat burst with last on beat 0.
- Valid outputs never drop before their ready. Request fields are constant while valid is high.
- Reset or clear mid-burst aborts immediately to IDLE. No response is drained.

Decomposition:
- Into nvdla_package:
  - state_dbb_init_t enum {INIT_IDLE, INIT_WR_REQ, INIT_WR_DATA, INIT_WR_RSP, INIT_RD_REQ, INIT_RD_DATA, INIT_DONE};
  - dbb_req_t struct {addr, len, id};
  - ctrl_dbb_init_t struct {start, rnw, addr, len, id};
  - flags_dbb_init_t struct {busy, done, err}.
- Single flat module, no sub-module: one FSM plus a beat counter.

Test Plan:
- Write, len=3, addr=0x1000, id=0x5A; stream 0xA0..0xA3, slave always ready → wr_req carries 0x1000/3/0x5A. Four data beats, last only on 0xA3. Response id 0x5A → done_o pulses once, err_o=0.
- Read, len=0, id=0x11; slave returns 0xDEAD with last=1, id 0x11 → data_o carries 0xDEAD. done_o pulses 1 cycle after the beat.
- Backpressure: random wr_dat_ready_i and data_o.ready at 50%, len=15 → exactly 16 beats, in order, none dropped or duplicated. Valid and data stay stable while stalled.
- Write response id 0x22 against latched 0x5A → err_o=1 and done_o pulses. The next start clears err_o.
- Read with rd_dat_last_i=1 on beat 1 of a len=3 burst → err_o=1 and done_o pulses after beat 1.
- Assert rst_i during WR_DATA beat 2 → all outputs 0 and busy_o=0 immediately. A new write start then completes normally.
